sdes_nonce_gen: RTL and testbench
=================================

Name: sdes_nonce_gen

Overview:
Sequential nonce source that sits directly upstream of the SDES block. It drives SDES's 8-bit nonce input from a seedable 8-bit maximal-length LFSR. The consumer takes nonces through a valid/ready handshake. After a programmable number of nonces, issue stops until software supplies a fresh seed, so the cipher never sees a repeated nonce within one seed epoch.

Parameters:
- RESEED_LIMIT, 255: nonces issued per seed epoch. Legal range 1..255; 255 gives one full LFSR period with no repeats.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- seed_load, input, 1: single-cycle pulse that loads `seed` and starts a new epoch.
- seed, input, 8: seed value; sampled only when seed_load=1.
- nonce, output, 8: current nonce; connects to SDES `nonce`.
- nonce_valid, output, 1: `nonce` is valid for transfer.
- nonce_ready, input, 1: consumer accepts `nonce` this cycle.
- reseed_req, output, 1: epoch exhausted; a new seed_load is required.
- issued_count, output, 8: nonces transferred in the current epoch.

Behaviour:
- Reset: state=IDLE, lfsr=8'h00, nonce=8'h00, nonce_valid=0, reseed_req=0, issued_count=0. Reset wins over every other input.
- `nonce` is the registered lfsr value. It carries no combinational path from any input.
- LFSR step: Fibonacci, shift left. next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, polynomial x^8+x^6+x^5+x^4+1, period 255, never reaches 0.
- Transfer = nonce_valid & nonce_ready. On a transfer: lfsr steps and issued_count increments on the same edge. Throughput is 1 nonce/cycle back-to-back.
- Backpressure: while nonce_valid=1 and nonce_ready=0, `nonce` and issued_count hold.
- State IDLE: nonce_valid=0, reseed_req=0, nonce_ready ignored.
  - seed_load -> ACTIVE.
- Seed load, from any state: on the next edge
  - lfsr = seed, except seed==8'h00 loads 8'h01 (lock-up avoidance);
  - issued_count=0, reseed_req=0, state=ACTIVE, nonce_valid=1 from the following cycle.
  - Seed load latency is 1 cycle.
- State ACTIVE: nonce_valid=1.
  - A transfer with issued_count==RESEED_LIMIT-1 -> EXHAUSTED. On that edge lfsr still steps and issued_count becomes RESEED_LIMIT.
- State EXHAUSTED: nonce_valid=0, reseed_req=1, lfsr and issued_count frozen, nonce_ready ignored.
  - seed_load -> ACTIVE.
- Simultaneous seed_load and transfer: the consumer has taken the current nonce (the transfer is legal); the seed load overrides the lfsr step and count increment. Result: lfsr=new seed, issued_count=0.
- seed_load in ACTIVE with no transfer: the current nonce is discarded and the epoch restarts immediately.
- issued_count never wraps; its maximum is RESEED_LIMIT ≤ 255.
- rst asserted mid-epoch returns to IDLE on the next edge. No nonce is presented until a new seed_load.

Test Plan:
- Reset, then idle with nonce_ready=1 -> nonce_valid=0, nonce=8'h00, reseed_req=0, issued_count=0 indefinitely.
- seed_load with seed=8'h01, nonce_ready held 1 -> nonce shows 01, 02, 04, 08, 11, 23 on consecutive cycles; issued_count shows 0..5.
- Seed 8'h01; nonce_ready=0 for 3 cycles after valid, then 1 -> nonce stays 8'h01 and issued_count=0 for 3 cycles; then 8'h02 follows.
- seed_load with seed=8'h00 -> first nonce 8'h01, then 8'h02.
- RESEED_LIMIT=4, seed 8'h01, ready=1:
  - after 4 transfers, nonce_valid=0, reseed_req=1, issued_count=4, and the frozen nonce=8'h11;
  - ready toggling causes no change;
  - seed_load with seed=8'h23 -> valid=1 and nonce=8'h23 the next cycle.
- RESEED_LIMIT=255, seed 8'hA5, ready=1:
  - expect 255 distinct nonzero nonces, then EXHAUSTED;
  - separately, seed_load=8'h10 coincident with a transfer -> next nonce=8'h10, issued_count=0.

Source files
------------

// File: rtl/sdes_nonce_gen.sv
// Nonce source for SDES: seedable 8-bit maximal-length LFSR behind a valid/ready
// handshake, stopping after RESEED_LIMIT transfers until a fresh seed arrives.
module sdes_nonce_gen #(
    parameter int unsigned RESEED_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_load,
    input  logic [7:0] seed,
    output logic [7:0] nonce,
    output logic       nonce_valid,
    input  logic       nonce_ready,
    output logic       reseed_req,
    output logic [7:0] issued_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_EXHAUSTED = 2'd2
    } state_e;

    localparam logic [7:0] LAST_IDX = 8'(RESEED_LIMIT - 1);

    state_e     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] count_q, count_d;
    logic       valid_q, valid_d;
    logic       reseed_q, reseed_d;
    logic       transfer_s;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; never maps a nonzero value to zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign transfer_s = valid_q & nonce_ready;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= 8'h00;
            count_q  <= 8'h00;
            valid_q  <= 1'b0;
            reseed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            reseed_q <= reseed_d;
        end
    end

    // Next-state logic; a seed load restarts the epoch from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (seed_load) begin
                    state_d = ST_ACTIVE;
                end else if (transfer_s && (count_q == LAST_IDX)) begin
                    state_d = ST_EXHAUSTED;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_EXHAUSTED: begin
                if (seed_load) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_EXHAUSTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: a seed load overrides the step of a coincident transfer.
    always_comb begin
        lfsr_d  = lfsr_q;
        count_d = count_q;
        if (seed_load) begin
            lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
            count_d = 8'h00;
        end else if (transfer_s) begin
            lfsr_d  = lfsr_step(lfsr_q);
            count_d = count_q + 8'd1;
        end else begin
            lfsr_d  = lfsr_q;
            count_d = count_q;
        end
    end

    // Output decode from the next state so valid/reseed come straight from flops.
    always_comb begin
        valid_d  = 1'b0;
        reseed_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                valid_d  = 1'b0;
                reseed_d = 1'b0;
            end
            ST_ACTIVE: begin
                valid_d  = 1'b1;
                reseed_d = 1'b0;
            end
            ST_EXHAUSTED: begin
                valid_d  = 1'b0;
                reseed_d = 1'b1;
            end
            default: begin
                valid_d  = 1'b0;
                reseed_d = 1'b0;
            end
        endcase
    end

    assign nonce        = lfsr_q;
    assign nonce_valid  = valid_q;
    assign reseed_req   = reseed_q;
    assign issued_count = count_q;

endmodule

// File: tb/tb_sdes_nonce_gen.sv
// Scoreboard bench for sdes_nonce_gen: one instance with a short epoch (4) and one
// with a full-period epoch (255), checked against a position-in-period model.
module tb_sdes_nonce_gen;

    logic       clk;
    logic       rst;
    logic       sl      [2];
    logic [7:0] sd      [2];
    logic       rd      [2];
    logic [7:0] nonce_o [2];
    logic       valid_o [2];
    logic       reseed_o[2];
    logic [7:0] count_o [2];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference: the 255-entry LFSR period, and where each value sits in it.
    logic [7:0] tbl    [255];
    int         pos_of [256];
    int         lim    [2] = '{4, 255};
    int         m_st   [2] = '{0, 0};
    int         m_k    [2] = '{0, 0};
    int         m_base [2] = '{0, 0};

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [255:0] seen1;
    bit           full_done;

    sdes_nonce_gen #(.RESEED_LIMIT(4)) u_small (
        .clk(clk), .rst(rst), .seed_load(sl[0]), .seed(sd[0]),
        .nonce(nonce_o[0]), .nonce_valid(valid_o[0]), .nonce_ready(rd[0]),
        .reseed_req(reseed_o[0]), .issued_count(count_o[0])
    );

    sdes_nonce_gen #(.RESEED_LIMIT(255)) u_full (
        .clk(clk), .rst(rst), .seed_load(sl[1]), .seed(sd[1]),
        .nonce(nonce_o[1]), .nonce_valid(valid_o[1]), .nonce_ready(rd[1]),
        .reseed_req(reseed_o[1]), .issued_count(count_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] exp_nonce(input int i);
        if (m_st[i] == 0) return 8'h00;
        return tbl[(m_base[i] + m_k[i]) % 255];
    endfunction

    // Advance the model by the inputs that were applied during the cycle just ended.
    task automatic model_edge(input int i);
        logic [7:0] s;
        if (rst) begin
            m_st[i] = 0; m_k[i] = 0; m_base[i] = 0;
        end else if (sl[i]) begin
            s = (sd[i] == 8'h00) ? 8'h01 : sd[i];
            m_st[i] = 1; m_k[i] = 0; m_base[i] = pos_of[s];
        end else if (m_st[i] == 1 && rd[i]) begin
            m_k[i]++;
            if (m_k[i] == lim[i]) m_st[i] = 2;
        end
    endtask

    task automatic step(input bit r, input bit sl0, input logic [7:0] sd0, input bit rd0,
                        input bit sl1, input logic [7:0] sd1, input bit rd1);
        @(posedge clk);
        #1;
        model_edge(0);
        model_edge(1);
        rst = r;
        sl[0] = sl0; sd[0] = sd0; rd[0] = rd0;
        sl[1] = sl1; sd[1] = sd1; rd[1] = rd1;
        if (m_st[0] == 1 && rd0) q0.push_back({exp_nonce(0), 8'(m_k[0])});
        if (m_st[1] == 1 && rd1) q1.push_back({exp_nonce(1), 8'(m_k[1])});
    endtask

    task automatic both(input bit r, input bit s, input logic [7:0] v, input bit rdy, input int n);
        for (int c = 0; c < n; c++) step(r, s, v, rdy, s, v, rdy);
    endtask

    task automatic monitor(input int i);
        logic [15:0] e;
        string tag;
        tag = (i == 0) ? "small" : "full";
        check({tag, ".valid"},  int'(valid_o[i]),  int'(m_st[i] == 1));
        check({tag, ".reseed"}, int'(reseed_o[i]), int'(m_st[i] == 2));
        check({tag, ".count"},  int'(count_o[i]),  m_k[i]);
        check({tag, ".nonce"},  int'(nonce_o[i]),  int'(exp_nonce(i)));
        if (valid_o[i] && rd[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                check({tag, ".unexpected_xfer"}, 1, 0);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check({tag, ".xfer_nonce"}, int'(nonce_o[i]), int'(e[15:8]));
                check({tag, ".xfer_count"}, int'(count_o[i]), int'(e[7:0]));
            end
            if (i == 1) seen1[nonce_o[1]] = 1'b1;
        end
        if (i == 1) begin
            if (reseed_o[1] && !full_done) begin
                check("full.distinct", $countones(seen1[255:1]), 255);
                check("full.no_zero", int'(seen1[0]), 0);
                full_done = 1'b1;
            end
            if (sl[1] || rst) begin
                seen1 = '0;
                full_done = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    initial begin
        logic [7:0] v;
        v = 8'h01;
        for (int j = 0; j < 255; j++) begin
            tbl[j] = v;
            pos_of[v] = j;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        pos_of[0] = 0;
        seen1 = '0;
        full_done = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sl[i] = 1'b0; sd[i] = 8'h00; rd[i] = 1'b0;
        end

        both(1'b1, 1'b0, 8'h00, 1'b0, 3);
        both(1'b0, 1'b0, 8'h00, 1'b1, 5);       // idle ignores ready
        both(1'b0, 1'b1, 8'h01, 1'b1, 1);       // seed 01
        both(1'b0, 1'b0, 8'h00, 1'b1, 6);       // small exhausts at 4 with nonce 11
        for (int c = 0; c < 4; c++) both(1'b0, 1'b0, 8'h00, 1'(c), 1);
        step(1'b0, 1'b1, 8'h23, 1'b1, 1'b1, 8'h01, 1'b0);
        both(1'b0, 1'b0, 8'h00, 1'b0, 3);       // backpressure holds
        both(1'b0, 1'b0, 8'h00, 1'b1, 2);
        both(1'b0, 1'b1, 8'h00, 1'b0, 1);       // zero seed loads 01
        both(1'b0, 1'b0, 8'h00, 1'b1, 2);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1);
        both(1'b0, 1'b0, 8'h00, 1'b1, 260);     // full epoch then exhausted
        both(1'b0, 1'b1, 8'h33, 1'b1, 1);
        both(1'b0, 1'b0, 8'h00, 1'b1, 3);
        both(1'b0, 1'b1, 8'h10, 1'b1, 1);       // load coincident with transfer
        both(1'b0, 1'b0, 8'h00, 1'b1, 2);
        both(1'b0, 1'b1, 8'h5C, 1'b0, 1);
        both(1'b0, 1'b0, 8'h00, 1'b1, 2);
        both(1'b1, 1'b0, 8'h00, 1'b1, 1);       // mid-epoch reset
        both(1'b0, 1'b0, 8'h00, 1'b1, 4);

        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 15) == 0), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 63) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        both(1'b0, 1'b0, 8'h00, 1'b0, 2);
        @(negedge clk);
        #1;
        check("small.queue_drained", q0.size(), 0);
        check("full.queue_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
